// File: rtl/sample_writer_if.sv
// Sample stream in / memory write bus out for sample_writer.
//   adc_data  : 8-bit unsigned ADC sample
//   adc_valid : adc_data valid this cycle
//   mem_addr  : sample memory write address
//   mem_wdata : sample memory write data
//   mem_we    : one-cycle write strobe
// master = the writer (consumes samples, drives memory writes)
// slave  = the environment (ADC source + sample memory)
interface sample_writer_if;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;

  modport master (input adc_data, adc_valid, output mem_addr, mem_wdata, mem_we);
  modport slave  (output adc_data, adc_valid, input mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/sample_writer.sv
// sample_writer: arms on activate, waits for a rising-edge trigger (or the
// first valid sample when triggering is disabled), then writes every
// (decim+1)-th valid ADC sample to a SAMPLES-deep memory and pulses done.
// Ports:
//   clk_50mhz   : clock, rising edge
//   reset       : async active-low reset
//   activate    : start a capture (sampled in idle only)
//   abort       : drop back to idle from any state, no done
//   done        : one-cycle pulse on capture completion
//   busy        : high whenever not idle
//   trig_enable : 1 = wait for trigger, 0 = free run
//   trig_level  : rising-edge threshold (latched on activate)
//   decim       : write one sample per decim+1 valid samples (latched)
//   bus         : ADC in / memory write out (sample_writer_if.master)
module sample_writer #(
  parameter int SAMPLES = 256
) (
  input  logic            clk_50mhz,
  input  logic            reset,
  input  logic            activate,
  input  logic            abort,
  output logic            done,
  output logic            busy,
  input  logic            trig_enable,
  input  logic [7:0]      trig_level,
  input  logic [15:0]     decim,
  sample_writer_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [7:0] LAST_ADDR = 8'(SAMPLES - 1);

  logic [1:0]  state;
  logic [15:0] decim_q;
  logic [15:0] dcnt;
  logic [7:0]  level_q;
  logic [7:0]  prev;
  logic        prev_ok;
  logic        last;      // final write has been issued; ignore further samples
  logic [7:0]  next_addr;
  logic        trig_hit;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // mem_addr advances at the end of each write cycle, so a sample accepted
  // during a write cycle lands one address beyond the one currently shown.
  assign next_addr = bus.mem_addr + {7'd0, bus.mem_we};

  assign trig_hit = !trig_enable ||
                    (prev_ok && (prev < level_q) && (bus.adc_data >= level_q));

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      decim_q       <= '0;
      dcnt          <= '0;
      level_q       <= '0;
      prev          <= '0;
      prev_ok       <= 1'b0;
      last          <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (abort) begin
        // abort beats any pending write and any activate
        state <= ST_IDLE;
        last  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (activate) begin
              state        <= ST_ARM;
              bus.mem_addr <= '0;
              prev_ok      <= 1'b0;
              decim_q      <= decim;
              level_q      <= trig_level;
            end
          end
          ST_ARM: begin
            if (bus.adc_valid) begin
              prev    <= bus.adc_data;
              prev_ok <= 1'b1;
              if (trig_hit) begin
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= bus.adc_data;
                dcnt          <= decim_q;
                last          <= (LAST_ADDR == 8'd0);
                state         <= ST_CAPTURE;
              end
            end
          end
          ST_CAPTURE: begin
            if (bus.mem_we) begin
              if (last) begin
                state <= ST_DONE;
                last  <= 1'b0;
              end else begin
                bus.mem_addr <= bus.mem_addr + 8'd1;
              end
            end
            if (bus.adc_valid && !last) begin
              if (dcnt == 16'd0) begin
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= bus.adc_data;
                dcnt          <= decim_q;
                last          <= (next_addr == LAST_ADDR);
              end else begin
                dcnt <= dcnt - 16'd1;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
